// File: rtl/bcd_bin_top_if.sv
// ---------------------------------------------------------------------------
// bcd_bin_top_if
// Purpose : groups the request/result signals of the BCD-to-binary converter.
//
// Ports / signals:
//   start  request a conversion, sampled on the rising clock edge
//   bcd    packed BCD operand, digit k at bits [4k+3:4k], digit 0 least significant
//   bin    registered binary result
//   err    registered flag, 1 when the last accepted operand held a digit > 9
//   done   1 while the converter is idle and bin/err are valid
//
// Modports:
//   master  drives start/bcd and observes bin/err/done (requester side)
//   slave   receives start/bcd and drives bin/err/done (converter side)
// ---------------------------------------------------------------------------
interface bcd_bin_top_if #(
  parameter int digits = 2,
  parameter int width  = 7
);

  logic                  start;
  logic [4*digits-1:0]   bcd;
  logic [width-1:0]      bin;
  logic                  err;
  logic                  done;

  modport master (
    output start,
    output bcd,
    input  bin,
    input  err,
    input  done
  );

  modport slave (
    input  start,
    input  bcd,
    output bin,
    output err,
    output done
  );

endinterface

// File: rtl/bcd_bin_top.sv
// ---------------------------------------------------------------------------
// bcd_bin_top
// Purpose : iterative BCD-to-binary converter using reverse double dabble
//           (shift right one bit per clock, then subtract 3 from every BCD
//           digit that reads 8 or more). A conversion takes exactly width
//           clocks after the accepting edge.
//
// Ports:
//   clk   single clock, all state changes on the rising edge
//   rst   synchronous active-high reset, has priority over start
//   bus   bcd_bin_top_if.slave: start/bcd in, bin/err/done out
//
// Parameters:
//   digits  number of packed BCD input digits (>= 1)
//   width   binary result width, caller guarantees 2^width > 10^digits - 1
// ---------------------------------------------------------------------------
module bcd_bin_top #(
  parameter int digits = 2,
  parameter int width  = 7
) (
  input  logic         clk,
  input  logic         rst,
  bcd_bin_top_if.slave bus
);

  localparam int DW = 4 * digits;
  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(width - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t            state;
  logic [DW-1:0]     bcd_reg;
  logic [width-1:0]  acc;
  logic [CW-1:0]     cnt;
  logic              invalid;
  logic [width-1:0]  bin_r;
  logic              err_r;

  logic [DW-1:0]     step_bcd;
  logic [width-1:0]  step_acc;
  logic              in_invalid;

  // Flags an operand on the bus that contains any digit above 9; captured
  // once at the accepting edge so later bcd changes cannot affect it.
  always_comb begin
    in_invalid = 1'b0;
    for (int k = 0; k < digits; k++) begin
      if (bus.bcd[4*k +: 4] > 4'd9) begin
        in_invalid = 1'b1;
      end
    end
  end

  // One reverse-double-dabble step: the BCD LSB falls into the accumulator
  // MSB, then each shifted digit that reads 8..15 is corrected by -3. Bit 3
  // of a digit being set is the same as the digit being >= 8. Digits are
  // corrected independently, so no borrow crosses a digit boundary.
  always_comb begin
    step_bcd = {1'b0, bcd_reg[DW-1:1]};
    step_acc = {bcd_reg[0], acc[width-1:1]};
    for (int k = 0; k < digits; k++) begin
      if (step_bcd[4*k+3]) begin
        step_bcd[4*k +: 4] = step_bcd[4*k +: 4] - 4'd3;
      end
    end
  end

  // Control FSM and datapath registers. bin/err are written only on the
  // edge completing the last step, so they hold steady during a conversion
  // and an aborted conversion never leaks a partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_reg <= '0;
      acc     <= '0;
      cnt     <= '0;
      invalid <= 1'b0;
      bin_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bcd_reg <= bus.bcd;
            acc     <= '0;
            cnt     <= '0;
            invalid <= in_invalid;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_reg <= step_bcd;
          acc     <= step_acc;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            bin_r <= invalid ? '0 : step_acc;
            err_r <= invalid;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bin  = bin_r;
  assign bus.err  = err_r;
  assign bus.done = (state == IDLE);

endmodule

// File: tb/tb_bcd_bin_top.sv
// ---------------------------------------------------------------------------
// tb_bcd_bin_top
// Purpose : self-checking bench for bcd_bin_top. The stimulus process issues
//           conversions and pushes the expected result (from a decimal
//           reference model) into a queue; a separate monitor pops and
//           compares each completed result, checks latency, hold behaviour
//           of bin/err, and reset values.
// ---------------------------------------------------------------------------
module tb_bcd_bin_top;

  localparam int DIGITS = 2;
  localparam int WIDTH  = 7;
  localparam int TIMEOUT = 200;

  typedef struct {
    int bin;
    bit err;
  } result_t;

  logic clk;
  logic rst;

  bcd_bin_top_if #(.digits(DIGITS), .width(WIDTH)) bus ();

  bcd_bin_top #(.digits(DIGITS), .width(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  result_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain decimal arithmetic on the digits of the operand.
  function automatic result_t ref_model(input logic [4*DIGITS-1:0] v);
    result_t r;
    int      scale;
    int      d;
    r.bin = 0;
    r.err = 1'b0;
    scale = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'((v >> (4 * k)) & 15);
      if (d > 9) r.err = 1'b1;
      r.bin = r.bin + d * scale;
      scale = scale * 10;
    end
    if (r.err) r.bin = 0;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) until the converter reports idle; inputs are driven
  // 1 time unit after the rising edge, away from the sampling point.
  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.done !== 1'b1) begin
      check_output("wait_idle_timeout", 32'(bus.done), 32'd1);
    end
  endtask

  // Issues one conversion: a one-cycle start pulse, then scrambles bcd to
  // show that the captured operand is used. Optionally pulses start again
  // mid-conversion, which must be ignored.
  task automatic apply_stimulus(input logic [4*DIGITS-1:0] v, input bit pulse_mid);
    wait_idle();
    bus.start = 1'b1;
    bus.bcd   = v;
    exp_q.push_back(ref_model(v));
    pushes++;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bcd   = 8'($urandom);
    if (pulse_mid) begin
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.bcd   = 8'($urandom);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  // Monitor: samples on the falling edge. rst_prev holds the reset level
  // that applied at the rising edge just before this sample.
  initial begin
    bit rst_prev;
    bit in_conv;
    int lat;
    int held_bin;
    bit held_err;
    result_t e;
    rst_prev = 1'b1;
    in_conv  = 1'b0;
    lat      = 0;
    held_bin = 0;
    held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        check_output("reset_done", 32'(bus.done), 32'd1);
        check_output("reset_bin", 32'(bus.bin), 32'd0);
        check_output("reset_err", 32'(bus.err), 32'd0);
        held_bin = 0;
        held_err = 1'b0;
        in_conv  = 1'b0;
      end else if (in_conv && bus.done === 1'b1) begin
        check_output("latency", 32'(lat), 32'(WIDTH));
        if (exp_q.size() == 0) begin
          check_output("unexpected_result", 32'(bus.bin), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          pops++;
          check_output("bin", 32'(bus.bin), 32'(e.bin));
          check_output("err", 32'(bus.err), 32'(e.err));
        end
        held_bin = int'(bus.bin);
        held_err = bus.err;
        in_conv  = 1'b0;
      end else begin
        check_output("hold_bin", 32'(bus.bin), 32'(held_bin));
        check_output("hold_err", 32'(bus.err), 32'(held_err));
        if (bus.done !== 1'b1) begin
          if (in_conv) lat++;
          else begin
            in_conv = 1'b1;
            lat     = 1;
          end
        end
      end
      rst_prev = rst;
    end
  end

  // Stimulus process.
  initial begin
    int c;
    bit seen_done;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bcd   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed 8'h42");
    apply_stimulus(8'h42, 1'b0);

    $display("[TB] sweep of all valid codes");
    for (int v = 0; v < 100; v++) begin
      apply_stimulus({4'(v / 10), 4'(v % 10)}, 1'b0);
    end

    $display("[TB] invalid digits");
    apply_stimulus(8'h5A, 1'b0);
    apply_stimulus(8'hF3, 1'b0);
    apply_stimulus(8'h17, 1'b0);

    $display("[TB] random operands");
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] start held high");
    wait_idle();
    bus.start = 1'b1;
    bus.bcd   = 8'h25;
    exp_q.push_back(ref_model(8'h25));
    pushes++;
    @(posedge clk);
    #1;
    c = 0;
    seen_done = 1'b0;
    while (c < TIMEOUT && !(seen_done && bus.done === 1'b0)) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 3) begin
        bus.bcd = 8'h88;
        exp_q.push_back(ref_model(8'h88));
        pushes++;
      end
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    check_output("back_to_back_period", 32'(c), 32'(WIDTH + 1));
    bus.start = 1'b0;
    bus.bcd   = 8'($urandom);

    $display("[TB] reset during conversion");
    wait_idle();
    bus.start = 1'b1;
    bus.bcd   = 8'h63;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("abort_done", 32'(bus.done), 32'd1);
    check_output("abort_bin", 32'(bus.bin), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check_output("abort_no_spurious", 32'(bus.done), 32'd1);

    apply_stimulus(8'h99, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("results_seen", 32'(pops), 32'(pushes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
